// File: rtl/rob_retire_unit.sv
// Reorder buffer with in-order, multi-wide retire. Completion comes from the EXE and MEM
// channels. A retiring mispredicted branch flushes the whole buffer.

module rob_retire_slot (
  input  logic i_prev_go,
  input  logic i_prev_store,
  input  logic i_prev_mis,
  input  logic i_valid,
  input  logic i_done,
  input  logic i_store,
  input  logic i_mis,
  output logic o_go,
  output logic o_store_seen,
  output logic o_mis_seen
);
  // A slot retires only when every older slot retires. Only one store may retire per cycle,
  // and nothing younger than a mispredicted branch may retire.
  assign o_go         = i_prev_go & i_valid & i_done & ~(i_store & i_prev_store) & ~i_prev_mis;
  assign o_store_seen = i_prev_store | (o_go & i_store);
  assign o_mis_seen   = i_prev_mis | (o_go & i_mis);
endmodule

module rob_retire_unit #(
  parameter  int NUM_PHYS_REGS = 64,
  parameter  int ROB_DEPTH     = 32,
  parameter  int RETIRE_WIDTH  = 2,
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS),
  localparam int LOG_ROB       = $clog2(ROB_DEPTH)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           alloc_valid,
  input  logic                           alloc_has_dest,
  input  logic [4:0]                     alloc_arch_dest,
  input  logic [LOG_PHYS-1:0]            alloc_phys_dest,
  input  logic [LOG_PHYS-1:0]            alloc_old_phys,
  input  logic                           alloc_is_store,
  input  logic [31:0]                    alloc_pc,
  output logic [LOG_ROB-1:0]             alloc_tag,
  output logic                           stall_signal,
  input  logic                           exe_done,
  input  logic [LOG_ROB-1:0]             exe_tag,
  input  logic                           exe_mispredict,
  input  logic                           mem_done,
  input  logic [LOG_ROB-1:0]             mem_tag,
  input  logic [31:0]                    mem_store_addr,
  input  logic [31:0]                    mem_store_data,
  input  logic [1:0]                     mem_store_size,
  output logic [RETIRE_WIDTH-1:0]        retire_valid,
  output logic [RETIRE_WIDTH-1:0]        retire_has_dest,
  output logic [5*RETIRE_WIDTH-1:0]      retire_arch_dest,
  output logic [LOG_PHYS*RETIRE_WIDTH-1:0] retire_phys_dest,
  output logic [LOG_PHYS*RETIRE_WIDTH-1:0] retire_free_phys,
  output logic                           MemWrite_2DM,
  output logic [31:0]                    data_address_2DM,
  output logic [31:0]                    data_write_2DM,
  output logic [1:0]                     data_write_size_2DM,
  output logic                           mispredict_recover,
  output logic [31:0]                    recover_pc
);
  localparam int RW = RETIRE_WIDTH;

  logic [LOG_ROB-1:0] r_head, r_tail;
  logic [LOG_ROB:0]   r_count;
  logic [ROB_DEPTH-1:0] r_valid, r_done, r_mis, r_has_dest, r_store;
  logic [ROB_DEPTH-1:0][4:0]          r_arch;
  logic [ROB_DEPTH-1:0][LOG_PHYS-1:0] r_phys, r_old;
  logic [ROB_DEPTH-1:0][31:0]         r_pc, r_saddr, r_sdata;
  logic [ROB_DEPTH-1:0][1:0]          r_ssize;

  logic [RW-1:0]              r_ret_valid, r_ret_has_dest;
  logic [RW-1:0][4:0]         r_ret_arch;
  logic [RW-1:0][LOG_PHYS-1:0] r_ret_phys, r_ret_free;
  logic        r_mw, r_rec;
  logic [31:0] r_addr, r_data, r_rpc;
  logic [1:0]  r_size;

  logic [RW-1:0][LOG_ROB-1:0] w_idx;
  logic [RW:0]   w_go_c, w_st_c, w_mis_c;
  logic [RW-1:0] w_go;
  logic [LOG_ROB:0] w_nret;
  logic        w_st_hit, w_flush, w_alloc;
  logic [31:0] w_st_addr, w_st_data, w_flush_pc;
  logic [1:0]  w_st_size;

  assign w_go_c[0]  = 1'b1;
  assign w_st_c[0]  = 1'b0;
  assign w_mis_c[0] = 1'b0;

  for (genvar k = 0; k < RW; k++) begin : g_slot
    assign w_idx[k] = r_head + LOG_ROB'(k);
    rob_retire_slot u_slot (
      .i_prev_go   (w_go_c[k]),
      .i_prev_store(w_st_c[k]),
      .i_prev_mis  (w_mis_c[k]),
      .i_valid     (r_valid[w_idx[k]]),
      .i_done      (r_done[w_idx[k]]),
      .i_store     (r_store[w_idx[k]]),
      .i_mis       (r_mis[w_idx[k]]),
      .o_go        (w_go_c[k+1]),
      .o_store_seen(w_st_c[k+1]),
      .o_mis_seen  (w_mis_c[k+1])
    );
  end

  assign w_go         = w_go_c[RW:1];
  assign w_flush      = w_mis_c[RW];
  assign stall_signal = (r_count == (LOG_ROB+1)'(ROB_DEPTH));
  assign w_alloc      = alloc_valid & ~stall_signal;
  assign alloc_tag    = r_tail;

  always_comb begin
    w_nret     = '0;
    w_st_hit   = 1'b0;
    w_st_addr  = '0;
    w_st_data  = '0;
    w_st_size  = '0;
    w_flush_pc = '0;
    for (int k = 0; k < RW; k++) begin
      if (w_go[k]) begin
        w_nret = w_nret + (LOG_ROB+1)'(1);
        if (r_store[w_idx[k]]) begin
          w_st_hit  = 1'b1;
          w_st_addr = r_saddr[w_idx[k]];
          w_st_data = r_sdata[w_idx[k]];
          w_st_size = r_ssize[w_idx[k]];
        end
        if (r_mis[w_idx[k]]) w_flush_pc = r_pc[w_idx[k]];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_head <= '0; r_tail <= '0; r_count <= '0;
      r_valid <= '0; r_done <= '0; r_mis <= '0;
      r_ret_valid <= '0; r_ret_has_dest <= '0;
      r_ret_arch <= '0; r_ret_phys <= '0; r_ret_free <= '0;
      r_mw <= 1'b0; r_addr <= '0; r_data <= '0; r_size <= '0;
      r_rec <= 1'b0; r_rpc <= '0;
    end else begin
      for (int k = 0; k < RW; k++) begin
        r_ret_valid[k]    <= w_go[k];
        r_ret_has_dest[k] <= w_go[k] & r_has_dest[w_idx[k]];
        r_ret_arch[k]     <= w_go[k] ? r_arch[w_idx[k]] : '0;
        r_ret_phys[k]     <= w_go[k] ? r_phys[w_idx[k]] : '0;
        r_ret_free[k]     <= w_go[k] ? r_old[w_idx[k]]  : '0;
      end
      r_mw   <= w_st_hit;
      r_addr <= w_st_addr;
      r_data <= w_st_data;
      r_size <= w_st_size;
      r_rec  <= w_flush;
      r_rpc  <= w_flush_pc;
      if (exe_done && r_valid[exe_tag]) begin
        r_done[exe_tag] <= 1'b1;
        r_mis[exe_tag]  <= exe_mispredict;
      end
      if (mem_done && r_valid[mem_tag]) r_done[mem_tag] <= 1'b1;
      for (int k = 0; k < RW; k++)
        if (w_go[k]) r_valid[w_idx[k]] <= 1'b0;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_mis[r_tail]   <= 1'b0;
      end
      r_head  <= r_head + w_nret[LOG_ROB-1:0];
      r_tail  <= r_tail + LOG_ROB'(w_alloc);
      r_count <= r_count + (LOG_ROB+1)'(w_alloc) - w_nret;
      // Mispredict flush overrides every pointer update and drops this cycle's allocation.
      if (w_flush) begin
        r_head <= '0; r_tail <= '0; r_count <= '0;
        r_valid <= '0;
      end
    end
  end

  // Payload needs no reset: it is only observed through valid/done.
  always_ff @(posedge CLK) begin
    if (w_alloc) begin
      r_has_dest[r_tail] <= alloc_has_dest;
      r_arch[r_tail]     <= alloc_arch_dest;
      r_phys[r_tail]     <= alloc_phys_dest;
      r_old[r_tail]      <= alloc_old_phys;
      r_store[r_tail]    <= alloc_is_store;
      r_pc[r_tail]       <= alloc_pc;
    end
    if (mem_done && r_valid[mem_tag]) begin
      r_saddr[mem_tag] <= mem_store_addr;
      r_sdata[mem_tag] <= mem_store_data;
      r_ssize[mem_tag] <= mem_store_size;
    end
  end

  assign retire_valid        = r_ret_valid;
  assign retire_has_dest     = r_ret_has_dest;
  assign retire_arch_dest    = r_ret_arch;
  assign retire_phys_dest    = r_ret_phys;
  assign retire_free_phys    = r_ret_free;
  assign MemWrite_2DM        = r_mw;
  assign data_address_2DM    = r_addr;
  assign data_write_2DM      = r_data;
  assign data_write_size_2DM = r_size;
  assign mispredict_recover  = r_rec;
  assign recover_pc          = r_rpc;
endmodule

// File: tb/tb_rob_retire_unit.sv
// Bench for rob_retire_unit: a queue-based ROB model checked every cycle, plus directed literal checks.

module tb_rob_retire_unit;
  localparam int RW = 2, DEPTH = 32, LP = 6;

  logic CLK = 1'b0, RESET = 1'b1;
  logic alloc_valid, alloc_has_dest, alloc_is_store;
  logic [4:0] alloc_arch_dest;
  logic [LP-1:0] alloc_phys_dest, alloc_old_phys;
  logic [31:0] alloc_pc;
  logic [4:0] alloc_tag;
  logic stall_signal;
  logic exe_done, exe_mispredict, mem_done;
  logic [4:0] exe_tag, mem_tag;
  logic [31:0] mem_store_addr, mem_store_data;
  logic [1:0] mem_store_size;
  logic [RW-1:0] retire_valid, retire_has_dest;
  logic [5*RW-1:0] retire_arch_dest;
  logic [LP*RW-1:0] retire_phys_dest, retire_free_phys;
  logic MemWrite_2DM, mispredict_recover;
  logic [31:0] data_address_2DM, data_write_2DM, recover_pc;
  logic [1:0] data_write_size_2DM;

  rob_retire_unit #(.NUM_PHYS_REGS(64), .ROB_DEPTH(DEPTH), .RETIRE_WIDTH(RW)) dut (
    .CLK(CLK), .RESET(RESET),
    .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest), .alloc_arch_dest(alloc_arch_dest),
    .alloc_phys_dest(alloc_phys_dest), .alloc_old_phys(alloc_old_phys), .alloc_is_store(alloc_is_store),
    .alloc_pc(alloc_pc), .alloc_tag(alloc_tag), .stall_signal(stall_signal),
    .exe_done(exe_done), .exe_tag(exe_tag), .exe_mispredict(exe_mispredict),
    .mem_done(mem_done), .mem_tag(mem_tag), .mem_store_addr(mem_store_addr),
    .mem_store_data(mem_store_data), .mem_store_size(mem_store_size),
    .retire_valid(retire_valid), .retire_has_dest(retire_has_dest), .retire_arch_dest(retire_arch_dest),
    .retire_phys_dest(retire_phys_dest), .retire_free_phys(retire_free_phys),
    .MemWrite_2DM(MemWrite_2DM), .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
    .data_write_size_2DM(data_write_size_2DM), .mispredict_recover(mispredict_recover), .recover_pc(recover_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int tag; bit hd; bit [4:0] arch; bit [LP-1:0] phys, old; bit st; bit [31:0] pc;
    bit done, mis; bit [31:0] addr, data; bit [1:0] size;
  } ent_t;
  ent_t q[$];
  int mtail;

  bit [RW-1:0] e_rv, e_hd;
  bit [5*RW-1:0] e_arch;
  bit [LP*RW-1:0] e_phys, e_free;
  bit e_mw, e_rec, e_stall;
  bit [31:0] e_addr, e_data, e_rpc;
  bit [1:0] e_size;

  int n_vec = 0, n_err = 0, n_ret = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_exp();
    e_rv = '0; e_hd = '0; e_arch = '0; e_phys = '0; e_free = '0;
    e_mw = 0; e_addr = 0; e_data = 0; e_size = 0; e_rec = 0; e_rpc = 0;
  endtask

  task automatic model_reset();
    q.delete(); mtail = 0; e_stall = 0; clr_exp();
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    int n, pre; bit st_seen, flush; ent_t e;
    clr_exp();
    n = 0; st_seen = 0; flush = 0;
    while (n < RW && n < q.size()) begin
      if (!q[n].done || (q[n].st && st_seen)) break;
      e_rv[n] = 1'b1; e_hd[n] = q[n].hd;
      e_arch[5*n +: 5] = q[n].arch;
      e_phys[LP*n +: LP] = q[n].phys;
      e_free[LP*n +: LP] = q[n].old;
      if (q[n].st) begin
        st_seen = 1; e_mw = 1; e_addr = q[n].addr; e_data = q[n].data; e_size = q[n].size;
      end
      if (q[n].mis) begin flush = 1; e_rec = 1; e_rpc = q[n].pc; end
      n++;
      if (flush) break;
    end
    foreach (q[i]) begin
      if (exe_done && q[i].tag == int'(exe_tag)) begin q[i].done = 1; q[i].mis = exe_mispredict; end
      if (mem_done && q[i].tag == int'(mem_tag)) begin
        q[i].done = 1; q[i].addr = mem_store_addr; q[i].data = mem_store_data; q[i].size = mem_store_size;
      end
    end
    pre = q.size();
    for (int k = 0; k < n; k++) void'(q.pop_front());
    if (flush) begin
      q.delete(); mtail = 0;
    end else if (alloc_valid && pre < DEPTH) begin
      e.tag = mtail; e.hd = alloc_has_dest; e.arch = alloc_arch_dest; e.phys = alloc_phys_dest;
      e.old = alloc_old_phys; e.st = alloc_is_store; e.pc = alloc_pc;
      e.done = 0; e.mis = 0; e.addr = 0; e.data = 0; e.size = 0;
      q.push_back(e);
      mtail = (mtail + 1) % DEPTH;
    end
    e_stall = (q.size() == DEPTH);
  endtask

  always @(negedge CLK) begin
    chk("retire_valid", 64'(retire_valid), 64'(e_rv));
    chk("retire_has_dest", 64'(retire_has_dest), 64'(e_hd));
    chk("retire_arch_dest", 64'(retire_arch_dest), 64'(e_arch));
    chk("retire_phys_dest", 64'(retire_phys_dest), 64'(e_phys));
    chk("retire_free_phys", 64'(retire_free_phys), 64'(e_free));
    chk("MemWrite_2DM", 64'(MemWrite_2DM), 64'(e_mw));
    chk("data_address_2DM", 64'(data_address_2DM), 64'(e_addr));
    chk("data_write_2DM", 64'(data_write_2DM), 64'(e_data));
    chk("data_write_size_2DM", 64'(data_write_size_2DM), 64'(e_size));
    chk("mispredict_recover", 64'(mispredict_recover), 64'(e_rec));
    chk("recover_pc", 64'(recover_pc), 64'(e_rpc));
    chk("stall_signal", 64'(stall_signal), 64'(e_stall));
    chk("alloc_tag", 64'(alloc_tag), 64'(mtail));
    n_ret += $countones(retire_valid);
  end

  task automatic idle();
    alloc_valid = 0; alloc_has_dest = 0; alloc_arch_dest = 0; alloc_phys_dest = 0;
    alloc_old_phys = 0; alloc_is_store = 0; alloc_pc = 0;
    exe_done = 0; exe_tag = 0; exe_mispredict = 0;
    mem_done = 0; mem_tag = 0; mem_store_addr = 0; mem_store_data = 0; mem_store_size = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    idle();
  endtask

  task automatic do_reset();
    RESET = 1; model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
  endtask

  task automatic set_alloc(input bit hd, input int arch, input int phys, input int old,
                           input bit st, input logic [31:0] pc);
    alloc_valid = 1; alloc_has_dest = hd; alloc_arch_dest = 5'(arch);
    alloc_phys_dest = LP'(phys); alloc_old_phys = LP'(old); alloc_is_store = st; alloc_pc = pc;
  endtask

  task automatic set_exe(input int tag, input bit mis);
    exe_done = 1; exe_tag = 5'(tag); exe_mispredict = mis;
  endtask

  task automatic set_mem(input int tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    mem_done = 1; mem_tag = 5'(tag); mem_store_addr = a; mem_store_data = d; mem_store_size = s;
  endtask

  initial begin
    int base;
    idle();
    do_reset();

    // Reset with five live entries.
    for (int i = 0; i < 5; i++) begin set_alloc(1, i, i, i, 0, 32'h40 + 32'(4*i)); step(); end
    do_reset();
    chk("rst stall", 64'(stall_signal), 64'd0);
    chk("rst retire_valid", 64'(retire_valid), 64'd0);
    chk("rst alloc_tag", 64'(alloc_tag), 64'd0);
    set_alloc(1, 1, 1, 1, 0, 32'h80); step();
    chk("post-rst alloc_tag", 64'(alloc_tag), 64'd1);

    // Out-of-order completion, in-order two-wide retire.
    do_reset();
    for (int i = 0; i < 4; i++) begin set_alloc(1, i+1, 20+i, 10+i, 0, 32'h100 + 32'(4*i)); step(); end
    set_exe(3, 0); step(); chk("ooo none 3", 64'(retire_valid), 64'd0);
    set_exe(2, 0); step();
    set_exe(1, 0); step(); chk("ooo none 1", 64'(retire_valid), 64'd0);
    set_exe(0, 0); step(); chk("ooo none 0", 64'(retire_valid), 64'd0);
    step();
    chk("ooo rv01", 64'(retire_valid), 64'h3);
    chk("ooo free01", 64'(retire_free_phys), 64'h2CA);
    chk("ooo arch01", 64'(retire_arch_dest), 64'h041);
    step();
    chk("ooo rv23", 64'(retire_valid), 64'h3);
    chk("ooo free23", 64'(retire_free_phys), 64'h34C);
    step();
    chk("ooo drained", 64'(retire_valid), 64'd0);

    // Full ROB: stall, ignored allocation, release after a two-wide retire.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin set_alloc(1, i, i, i, 0, 32'h1000 + 32'(4*i)); step(); end
    chk("full stall", 64'(stall_signal), 64'd1);
    set_alloc(1, 3, 3, 3, 0, 32'hBAD0); step();
    chk("full ignored tag", 64'(alloc_tag), 64'd0);
    set_alloc(1, 3, 3, 3, 0, 32'hBAD4); set_exe(0, 0); set_mem(1, 0, 0, 0); step();
    chk("full still stall", 64'(stall_signal), 64'd1);
    set_alloc(1, 3, 3, 3, 0, 32'hBAD8); step();
    chk("full retire2", 64'(retire_valid), 64'h3);
    chk("full released", 64'(stall_signal), 64'd0);
    chk("full tag=old head", 64'(alloc_tag), 64'd0);
    set_alloc(1, 4, 4, 4, 0, 32'h2000); step();
    chk("full next tag", 64'(alloc_tag), 64'd1);

    // Two adjacent stores retire one per cycle.
    do_reset();
    set_alloc(0, 0, 0, 0, 1, 32'h200); step();
    set_alloc(0, 0, 0, 0, 1, 32'h204); step();
    set_mem(1, 32'h2000, 32'hDEADBEEF, 2'd1); step();
    set_mem(0, 32'h1000, 32'h12345678, 2'd2); step();
    step();
    chk("st1 mw", 64'(MemWrite_2DM), 64'd1);
    chk("st1 addr", 64'(data_address_2DM), 64'h1000);
    chk("st1 data", 64'(data_write_2DM), 64'h12345678);
    chk("st1 size", 64'(data_write_size_2DM), 64'd2);
    chk("st1 rv", 64'(retire_valid), 64'h1);
    step();
    chk("st2 mw", 64'(MemWrite_2DM), 64'd1);
    chk("st2 addr", 64'(data_address_2DM), 64'h2000);
    chk("st2 data", 64'(data_write_2DM), 64'hDEADBEEF);
    chk("st2 size", 64'(data_write_size_2DM), 64'd1);
    step();
    chk("st idle mw", 64'(MemWrite_2DM), 64'd0);

    // Mispredicted branch at tag 5 with younger entries already done.
    do_reset();
    for (int i = 0; i < 10; i++) begin set_alloc(1, i, 30+i, 40+i, 0, 32'h100 + 32'(4*i)); step(); end
    for (int i = 0; i < 5; i++) begin set_exe(i, 0); step(); end
    for (int i = 6; i < 10; i++) begin set_exe(i, 0); step(); end
    set_exe(5, 1); step();
    set_alloc(1, 7, 7, 7, 0, 32'hDEAD); step();
    chk("br rv alone", 64'(retire_valid), 64'h1);
    chk("br recover", 64'(mispredict_recover), 64'd1);
    chk("br recover_pc", 64'(recover_pc), 64'h114);
    chk("br alloc dropped", 64'(alloc_tag), 64'd0);
    step();
    chk("br recover off", 64'(mispredict_recover), 64'd0);
    chk("br no younger", 64'(retire_valid), 64'd0);
    set_alloc(1, 1, 1, 1, 0, 32'h300); step();
    chk("br next tag", 64'(alloc_tag), 64'd1);

    // Wrap: 100 allocate/complete/retire iterations.
    do_reset();
    base = n_ret;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) set_alloc(i % 3 != 0, i % 32, i % 64, (i + 7) % 64, i % 3 == 0, 32'h4000 + 32'(4*i));
      if (i >= 2) begin
        set_exe((i - 2) % 32, 0);
        if ((i - 2) % 3 == 0) set_mem((i - 2) % 32, 32'(16*i), $urandom, 2'(i % 4));
      end
      step();
    end
    repeat (4) step();
    chk("wrap retire total", 64'(n_ret - base), 64'd100);
    chk("wrap empty stall", 64'(stall_signal), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
